// File: rtl/addsub_acc_ctrl_if.sv
// Request, adder and result signals for addsub_acc_ctrl, bundled with
// master (requester/adder side) and slave (controller side) views.
interface addsub_acc_ctrl_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [N-1:0] operand;
    logic [N-1:0] adder_x;
    logic [N-1:0] adder_y;
    logic         adder_add_n;
    logic [N-1:0] adder_s;
    logic         adder_cout;
    logic         adder_ovf;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] acc;
    logic         carry;
    logic         ovf;
    logic         ovf_sticky;

    modport slave (
        input  in_valid, op, operand, adder_s, adder_cout, adder_ovf, out_ready,
        output in_ready, adder_x, adder_y, adder_add_n, out_valid,
               acc, carry, ovf, ovf_sticky
    );

    modport master (
        output in_valid, op, operand, adder_s, adder_cout, adder_ovf, out_ready,
        input  in_ready, adder_x, adder_y, adder_add_n, out_valid,
               acc, carry, ovf, ovf_sticky
    );
endinterface

// File: rtl/addsub_acc_ctrl.sv
// Accumulator controller wrapped around an external n-bit adder/subtractor.
// Define ADDSUB_ACC_SATURATE_EN to saturate acc on signed overflow instead of wrapping.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; in_ready and out_valid are registered and never depend
// combinationally on in_valid or out_ready.
module addsub_acc_ctrl #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    addsub_acc_ctrl_if.slave      bus,
    output logic [1:0]            o_dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_ADD   = 2'd1,
        OP_SUB   = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

    state_t       r_state;
    op_t          r_op;
    logic [N-1:0] r_operand;
    logic [N-1:0] r_acc;
    logic         r_carry;
    logic         r_ovf;
    logic         r_ovf_sticky;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [N-1:0] w_arith_acc;

`ifdef ADDSUB_ACC_SATURATE_EN
    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
    // Overflow can only push the result away from the sign of acc.
    assign w_arith_acc = bus.adder_ovf ? (r_acc[N-1] ? SAT_MIN : SAT_MAX) : bus.adder_s;
`else
    assign w_arith_acc = bus.adder_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_LOAD;
            r_operand    <= '0;
            r_acc        <= '0;
            r_carry      <= 1'b0;
            r_ovf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= op_t'(bus.op);
                        r_operand  <= bus.operand;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (r_op)
                        OP_LOAD, OP_CLEAR: begin
                            r_acc        <= (r_op == OP_LOAD) ? r_operand : '0;
                            r_carry      <= 1'b0;
                            r_ovf        <= 1'b0;
                            r_ovf_sticky <= 1'b0;
                        end
                        default: begin
                            r_acc        <= w_arith_acc;
                            r_carry      <= bus.adder_cout;
                            r_ovf        <= bus.adder_ovf;
                            r_ovf_sticky <= r_ovf_sticky | bus.adder_ovf;
                        end
                    endcase
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.adder_x     = r_acc;
    assign bus.adder_y     = r_operand;
    assign bus.adder_add_n = (r_op == OP_SUB);
    assign bus.acc         = r_acc;
    assign bus.carry       = r_carry;
    assign bus.ovf         = r_ovf;
    assign bus.ovf_sticky  = r_ovf_sticky;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Bench for addsub_acc_ctrl: behavioural adder/subtractor, reference model,
// result scoreboard, directed and random operation sequences.
module tb_addsub_acc_ctrl;
    localparam int N = 4;
    localparam int SMAX = (1 << (N - 1)) - 1;
    localparam int SMIN = -(1 << (N - 1));
    localparam logic [1:0] OP_LOAD = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2, OP_CLEAR = 2'd3;

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;
    int n_checks;
    int n_errors;
    logic [N+2:0] exp_q[$];

    logic [N-1:0] m_acc;
    logic         m_sticky;

    addsub_acc_ctrl_if #(.N(N)) bus ();

    addsub_acc_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Adder/subtractor stand-in: x + y, or x + ~y + 1 when add_n is set.
    logic [N:0] add_t;
    assign add_t = bus.adder_add_n ? ({1'b0, bus.adder_x} + {1'b0, ~bus.adder_y} + 1'b1)
                                   : ({1'b0, bus.adder_x} + {1'b0, bus.adder_y});
    assign bus.adder_s    = add_t[N-1:0];
    assign bus.adder_cout = add_t[N];
    assign bus.adder_ovf  = bus.adder_add_n
        ? ((bus.adder_x[N-1] != bus.adder_y[N-1]) && (add_t[N-1] != bus.adder_x[N-1]))
        : ((bus.adder_x[N-1] == bus.adder_y[N-1]) && (add_t[N-1] != bus.adder_x[N-1]));

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: updates m_acc/m_sticky, pushes {acc, carry, ovf, sticky}.
    task automatic model_push(input logic [1:0] op, input logic [N-1:0] opd);
        int sa, sb, r, ua, ub;
        logic c, o;
        logic [N-1:0] nacc;
        sa = $signed(m_acc);
        sb = $signed(opd);
        ua = int'(m_acc);
        ub = int'(opd);
        c = 1'b0;
        o = 1'b0;
        nacc = '0;
        case (op)
            OP_LOAD:  begin nacc = opd; m_sticky = 1'b0; end
            OP_CLEAR: begin nacc = '0;  m_sticky = 1'b0; end
            default: begin
                r = (op == OP_ADD) ? sa + sb : sa - sb;
                c = (op == OP_ADD) ? ((ua + ub) >= (1 << N)) : (ua >= ub);
                o = (r > SMAX) || (r < SMIN);
                nacc = r[N-1:0];
`ifdef ADDSUB_ACC_SATURATE_EN
                if (o) nacc = (r > 0) ? N'(SMAX) : N'(SMIN);
`endif
                m_sticky = m_sticky | o;
            end
        endcase
        m_acc = nacc;
        exp_q.push_back({nacc, c, o, m_sticky});
    endtask

    // Scoreboard: one comparison per result handshake.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 32'(exp_q.size()), 32'd1);
            end else begin
                check("sb_result", {bus.acc, bus.carry, bus.ovf, bus.ovf_sticky}, exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [N-1:0] opd);
        int waited;
        logic [N-1:0] prev;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        prev = m_acc;
        model_push(op, opd);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.operand = opd;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("exec_state", 32'(dbg_state), 32'd1);
        check("exec_out_valid", 32'(bus.out_valid), 32'd0);
        check("exec_in_ready", 32'(bus.in_ready), 32'd0);
        check("exec_add_n", 32'(bus.adder_add_n), 32'(op == OP_SUB));
        check("exec_adder_x", 32'(bus.adder_x), 32'(prev));
        check("exec_adder_y", 32'(bus.adder_y), 32'(opd));
        @(negedge clk);
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
        check("hold_state", 32'(dbg_state), 32'd2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_flags"}, {bus.acc, bus.carry, bus.ovf, bus.ovf_sticky}, 32'd0);
        check({tag, "_adder_y"}, 32'(bus.adder_y), 32'd0);
        check({tag, "_add_n"}, 32'(bus.adder_add_n), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_acc = '0;
        m_sticky = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = OP_LOAD;
        bus.operand = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Directed sequences
        do_op(OP_LOAD, 4'd3);
        do_op(OP_LOAD, 4'd5);
        do_op(OP_ADD, 4'd2);
        do_op(OP_ADD, 4'd1);
        do_op(OP_ADD, 4'd0);
        do_op(OP_CLEAR, 4'd9);
        do_op(OP_LOAD, 4'd2);
        do_op(OP_SUB, 4'd3);
        do_op(OP_LOAD, 4'd3);
        do_op(OP_SUB, 4'd2);
        do_op(OP_LOAD, 4'd8);
        do_op(OP_SUB, 4'd1);
        do_op(OP_SUB, 4'd7);

        // Random sequence
        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), N'($urandom_range(0, (1 << N) - 1)));
        end

        // Backpressure: result held, busy requests ignored
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        do_op(OP_ADD, 4'd3);
        bus.in_valid = 1'b1;
        bus.op = OP_LOAD;
        bus.operand = 4'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_acc_held", 32'(bus.acc), 32'(m_acc));
            check("bp_state", 32'(dbg_state), 32'd2);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_state", 32'(dbg_state), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_no_latch_in_hold", 32'(bus.adder_y), 32'd3);
        model_push(OP_LOAD, 4'd9);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_accept_state", 32'(dbg_state), 32'd1);
        check("bp_accept_adder_y", 32'(bus.adder_y), 32'd9);
        @(negedge clk);
        check("bp_accept_out_valid", 32'(bus.out_valid), 32'd1);

        // Reset during EXEC of ADD 4
        @(negedge clk);
        check("pre_rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = OP_ADD;
        bus.operand = 4'd4;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_exec_state", 32'(dbg_state), 32'd1);
        rst_n = 1'b0;
        m_acc = '0;
        m_sticky = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(negedge clk);
        check_reset_values("midrst_held");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_out_valid", 32'(bus.out_valid), 32'd0);
        end
        do_op(OP_LOAD, 4'd6);
        do_op(OP_SUB, 4'd6);

        repeat (3) @(negedge clk);
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
